// File: rtl/reset_release_sequencer_pkg.sv
// reset_release_sequencer_pkg: shared state encoding and limits for the reset sequencer
package reset_release_sequencer_pkg;
  typedef enum logic [1:0] {HOLD = 2'd0, WAIT_LOCK = 2'd1, RELEASE = 2'd2, RUN = 2'd3} state_t;
  localparam logic [7:0] LOCKLOSS_MAX = 8'd255;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/reset_release_sequencer_sync_2ff.sv
// reset_release_sequencer_sync_2ff: two-flop synchroniser for a single asynchronous bit
module reset_release_sequencer_sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_sync;
  always_ff @(posedge i_clk)
    if (i_rst) r_sync <= '0;
    else r_sync <= {r_sync[0], i_d};
  assign o_q = r_sync[1];
endmodule

// File: rtl/reset_release_sequencer.sv
// reset_release_sequencer: lock-aware staged reset release with heartbeat taps
module reset_release_sequencer
  import reset_release_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES = 63,
  parameter int LOCK_FILTER = 16,
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_GAP   = 8,
  parameter int HB_WIDTH    = 32,
  parameter int LED_WIDTH   = 4,
  parameter int LED_LSB     = 21,
  parameter int HB_GATED    = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_pll_locked,
  input  logic                  i_force_reset,
  output logic [NUM_STAGES-1:0] o_stage_reset,
  output logic                  o_all_running,
  output logic [LED_WIDTH-1:0]  o_led,
  output logic                  o_alive,
  output logic [7:0]            o_lock_loss_count
);
  localparam int CW = $clog2(max2(HOLD_CYCLES, STAGE_GAP) + 1);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(STAGE_GAP - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  state_t r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [FW-1:0] r_filt, w_filt;
  logic [NUM_STAGES-1:0] r_stage, w_stage;
  logic [HB_WIDTH-1:0] r_hb;
  logic [7:0] r_llc;
  logic r_run, w_lock_s, w_abort, w_lock_loss;
  reset_release_sequencer_sync_2ff u_sync (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_pll_locked), .o_q(w_lock_s)
  );
  assign w_lock_loss = !w_lock_s && (r_state == RELEASE || r_state == RUN);
  assign w_abort = r_state != HOLD && (i_force_reset || w_lock_loss);
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_filt = r_filt;
    w_stage = r_stage;
    if (w_abort) begin
      w_state = HOLD;
      w_cnt = '0;
      w_filt = '0;
      w_stage = '1;
    end else begin
      case (r_state)
        HOLD: begin
          w_cnt = (i_force_reset || r_cnt == HOLD_LAST) ? '0 : r_cnt + 1'b1;
          w_state = (!i_force_reset && r_cnt == HOLD_LAST) ? WAIT_LOCK : HOLD;
        end
        WAIT_LOCK: begin
          w_filt = (w_lock_s && r_filt != FILT_LAST) ? r_filt + 1'b1 : '0;
          if (w_lock_s && r_filt == FILT_LAST) begin
            w_cnt = '0;
            w_stage = r_stage << 1;
            w_state = NUM_STAGES == 1 ? RUN : RELEASE;
          end
        end
        RELEASE: begin
          w_cnt = r_cnt == GAP_LAST ? '0 : r_cnt + 1'b1;
          if (r_cnt == GAP_LAST) begin
            w_stage = r_stage << 1;
            w_state = w_stage == '0 ? RUN : RELEASE;
          end
        end
        RUN: w_state = RUN;
      endcase
    end
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_state <= HOLD;
      r_cnt <= '0;
      r_filt <= '0;
      r_stage <= '1;
      r_run <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_filt <= w_filt;
      r_stage <= w_stage;
      r_run <= w_state == RUN;
    end
  always_ff @(posedge i_clk)
    if (i_rst) r_llc <= '0;
    else if (w_lock_loss && r_llc != LOCKLOSS_MAX) r_llc <= r_llc + 8'd1;
  always_ff @(posedge i_clk)
    if (i_rst) r_hb <= '0;
    else r_hb <= (HB_GATED != 0 && !r_run) ? '0 : r_hb + HB_WIDTH'(1);
  assign o_stage_reset = r_stage;
  assign o_all_running = r_run;
  assign o_led = r_hb[LED_LSB+LED_WIDTH-1:LED_LSB];
  assign o_alive = r_hb[LED_LSB-1];
  assign o_lock_loss_count = r_llc;
endmodule

// File: tb/tb_reset_release_sequencer.sv
// tb_reset_release_sequencer: directed checks of staged release, abort paths and heartbeat
module tb_reset_release_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic pll_a = 1'b1, force_a = 1'b0, pll_b = 1'b1, force_b = 1'b0;
  logic [2:0] stage_a;
  logic [0:0] stage_b;
  logic run_a, run_b, alive_a, alive_b;
  logic [3:0] led_a, led_b;
  logic [7:0] llc_a, llc_b;
  int total = 0, bad = 0, now_t = -1;
  always #5 clk = ~clk;
  reset_release_sequencer dut_a (
    .i_clk(clk), .i_rst(rst), .i_pll_locked(pll_a), .i_force_reset(force_a),
    .o_stage_reset(stage_a), .o_all_running(run_a), .o_led(led_a), .o_alive(alive_a),
    .o_lock_loss_count(llc_a)
  );
  reset_release_sequencer #(.HOLD_CYCLES(4), .LOCK_FILTER(2), .NUM_STAGES(1), .HB_GATED(1), .LED_LSB(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_pll_locked(pll_b), .i_force_reset(force_b),
    .o_stage_reset(stage_b), .o_all_running(run_b), .o_led(led_b), .o_alive(alive_b),
    .o_lock_loss_count(llc_b)
  );
  typedef struct {int t; logic pll; logic [2:0] stage; logic run;} vec_t;
  vec_t tbl[9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0h want=%0h", name, now_t, act, exp);
    end
  endtask
  task automatic step_to(input int t);
    if (now_t < t) begin
      while (now_t < t) begin
        @(posedge clk);
        now_t++;
      end
      #1;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_stage_a", stage_a, 3'b111);
    chk("rst_run_a", run_a, 0);
    chk("rst_led_a", led_a, 0);
    chk("rst_alive_a", alive_a, 0);
    chk("rst_llc_a", llc_a, 0);
    chk("rst_stage_b", stage_b, 1);
    rst = 1'b0;
    now_t = -1;
  endtask
  task automatic run_nominal(input int base);
    for (int i = 0; i < 9; i++) begin
      pll_a = tbl[i].pll;
      step_to(base + tbl[i].t);
      chk("nom_stage", stage_a, tbl[i].stage);
      chk("nom_run", run_a, tbl[i].run);
    end
  endtask
  initial begin
    tbl = '{'{0, 1'b1, 3'b111, 1'b0}, '{62, 1'b1, 3'b111, 1'b0}, '{77, 1'b1, 3'b111, 1'b0},
            '{78, 1'b1, 3'b110, 1'b0}, '{85, 1'b1, 3'b110, 1'b0}, '{86, 1'b1, 3'b100, 1'b0},
            '{93, 1'b1, 3'b100, 1'b0}, '{94, 1'b1, 3'b000, 1'b1}, '{100, 1'b1, 3'b000, 1'b1}};
    do_reset();
    run_nominal(0);
    chk("nom_llc", llc_a, 0);
    pll_a = 1'b0;
    step_to(102);
    chk("loss_not_yet", stage_a, 3'b000);
    step_to(103);
    chk("loss_stage", stage_a, 3'b111);
    chk("loss_run", run_a, 0);
    chk("loss_llc", llc_a, 1);
    pll_a = 1'b1;
    run_nominal(104);
    force_a = 1'b1;
    step_to(205);
    chk("force_run_stage", stage_a, 3'b111);
    chk("force_run_llc", llc_a, 1);
    force_a = 1'b0;
    step_to(284);
    chk("rel_stage0", stage_a, 3'b110);
    force_a = 1'b1;
    step_to(285);
    chk("force_rel_stage", stage_a, 3'b111);
    chk("force_rel_llc", llc_a, 1);
    force_a = 1'b0;
    step_to(290);
    force_a = 1'b1;
    step_to(291);
    force_a = 1'b0;
    step_to(294);
    chk("force_held", stage_a, 3'b111);
    step_to(369);
    chk("hold_force_pre", stage_a, 3'b111);
    step_to(370);
    chk("hold_force_rel", stage_a, 3'b110);
    pll_a = 1'b0;
    do_reset();
    step_to(150);
    chk("late_wait", stage_a, 3'b111);
    step_to(200);
    pll_a = 1'b1;
    step_to(217);
    chk("late_pre", stage_a, 3'b111);
    step_to(218);
    chk("late_rel", stage_a, 3'b110);
    chk("late_llc", llc_a, 0);
    do_reset();
    step_to(4);
    chk("b_pre_stage", stage_b, 1);
    chk("b_pre_run", run_b, 0);
    chk("b_pre_led", led_b, 0);
    chk("b_pre_alive", alive_b, 0);
    step_to(5);
    chk("b_rel_stage", stage_b, 0);
    chk("b_rel_run", run_b, 1);
    chk("b_rel_alive", alive_b, 0);
    step_to(6);
    chk("b_hb1_alive", alive_b, 1);
    chk("b_hb1_led", led_b, 0);
    step_to(11);
    chk("b_hb6_led", led_b, 3);
    chk("b_hb6_alive", alive_b, 0);
    step_to(70);
    pll_a = 1'b0;
    step_to(71);
    pll_a = 1'b1;
    step_to(88);
    chk("glitch_pre", stage_a, 3'b111);
    step_to(89);
    chk("glitch_rel", stage_a, 3'b110);
    for (int i = 0; i < 300; i++) begin
      int n;
      pll_b = 1'b0;
      step_to(now_t + 3);
      pll_b = 1'b1;
      if (i == 0) begin
        chk("b_loss_stage", stage_b, 1);
        chk("b_loss_llc", llc_b, 1);
      end
      if (i == 254) chk("b_llc_255", llc_b, 255);
      n = 0;
      while (!run_b && n < 40) begin
        step_to(now_t + 1);
        n++;
      end
      if (!run_b) begin
        chk("b_relock_timeout", run_b, 1);
        break;
      end
    end
    chk("b_llc_sat", llc_b, 255);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
